// File: rtl/st2bus_pingpong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : st2bus_pkg
//  Purpose  : Shared types and constants for the st2bus_pingpong packer.
//  Revision : 1.0 - initial release
// ============================================================================
package st2bus_pkg;

  localparam int c_st_w_def      = 8;
  localparam int c_bus_w_def     = 512;
  localparam int c_max_words_def = 32;
  localparam int c_lanes_def     = c_bus_w_def / c_st_w_def;

  typedef logic [$clog2(c_max_words_def):0] wcnt_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_WAIT = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_OUT   = 2'd2
  } rd_state_e;

  function automatic int f_lanes(input int st_w, input int bus_w);
    return bus_w / st_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/st2bus_pingpong_if.sv
`default_nettype none
// ============================================================================
//  Module   : st2bus_pingpong_if
//  Purpose  : Stream-in / bus-out handshake bundle; slave = packer view.
//  Revision : 1.0 - initial release
// ============================================================================
interface st2bus_pingpong_if #(
  parameter int ST_W      = 8,
  parameter int BUS_W     = 512,
  parameter int MAX_WORDS = 32
);
  localparam int c_nw_w = $clog2(MAX_WORDS) + 1;

  logic [ST_W-1:0]   st_data;
  logic              st_valid;
  logic              st_sop;
  logic              st_eop;
  logic              st_ready;
  logic [BUS_W-1:0]  bus_data;
  logic              bus_valid;
  logic              bus_sop;
  logic              bus_eop;
  logic [c_nw_w-1:0] bus_nwords;
  logic              bus_ready;

  modport slave (
    input  st_data, st_valid, st_sop, st_eop, bus_ready,
    output st_ready, bus_data, bus_valid, bus_sop, bus_eop, bus_nwords
  );

  modport master (
    output st_data, st_valid, st_sop, st_eop, bus_ready,
    input  st_ready, bus_data, bus_valid, bus_sop, bus_eop, bus_nwords
  );
endinterface
`default_nettype wire

// File: rtl/st2bus_pingpong_st_bank_mem.sv
`default_nettype none
// ============================================================================
//  Module   : st_bank_mem
//  Purpose  : Simple dual-port two-bank word store, address {bank, word}, registered read.
//  Revision : 1.0 - initial release
// ============================================================================
module st_bank_mem #(
  parameter int BUS_W     = 512,
  parameter int MAX_WORDS = 32
) (
  input  wire logic                         clk_st,
  input  wire logic                         i_we,
  input  wire logic [$clog2(MAX_WORDS):0]   i_waddr,
  input  wire logic [BUS_W-1:0]             i_wdata,
  input  wire logic                         i_re,
  input  wire logic [$clog2(MAX_WORDS):0]   i_raddr,
  output logic      [BUS_W-1:0]             o_rdata
);
  logic [BUS_W-1:0] r_mem [2*MAX_WORDS];
  logic [BUS_W-1:0] r_rdata;

  always_ff @(posedge clk_st) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/st2bus_pingpong.sv
`default_nettype none
// ============================================================================
//  Module   : st2bus_pingpong
//  Purpose  : Packs an ST beat stream into bus words through a two-bank ping-pong
//             buffer. Optional checking mode: macro ST2BUS_PP_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module st2bus_pingpong
  import st2bus_pkg::*;
#(
  parameter int ST_W      = 8,
  parameter int BUS_W     = 512,
  parameter int MAX_WORDS = 32
) (
  input  wire logic          clk_st,
  input  wire logic          rst_n,
  st2bus_pingpong_if.slave   io
`ifdef ST2BUS_PP_CHECK_EN
  ,
  output logic               err_pulse
`endif
);
  localparam int c_lanes = f_lanes(ST_W, BUS_W);
  localparam int c_lw    = (c_lanes > 1) ? $clog2(c_lanes) : 1;
  localparam int c_ww    = $clog2(MAX_WORDS);
  localparam int c_nw    = c_ww + 1;

  // write side
  wr_state_e              r_wst, w_wst_nxt;
  logic                   r_wr_bank, w_wr_bank_nxt;
  logic [c_lw-1:0]        r_lane, w_lane_nxt, w_lane_e;
  logic [BUS_W-1:0]       r_acc, w_acc_nxt, w_acc_e, w_word;
  logic [c_nw-1:0]        r_wcnt, w_wcnt_nxt, w_wcnt_e;
  logic                   r_ovf, w_ovf_nxt, w_ovf_e;
  logic [1:0]             r_full, w_full_nxt;
  logic [1:0][c_nw-1:0]   r_nwords, w_nwords_nxt;
  logic                   r_st_ready, w_st_ready_nxt;
  logic                   w_beat, w_take, w_restart, w_room, w_close, w_we;
  logic                   w_err;
  // read side
  rd_state_e              r_rst, w_rst_nxt;
  logic                   r_rd_bank, w_rd_bank_nxt;
  logic [c_nw-1:0]        r_nw, w_nw_nxt, r_ridx, w_ridx_nxt;
  logic                   w_re, w_free, w_pop, w_can_issue;
  logic [1:0]             w_occ;
  logic [BUS_W-1:0]       w_rdata;
  logic                   r_pend, r_pend_sop, r_pend_eop;
  logic                   r_out_valid, r_out_sop, r_out_eop;
  logic [BUS_W-1:0]       r_out_data;
  logic                   r_sk_valid, r_sk_sop, r_sk_eop;
  logic [BUS_W-1:0]       r_sk_data;

  assign w_beat = io.st_valid & r_st_ready;

  always_comb begin
    w_wst_nxt     = r_wst;
    w_wr_bank_nxt = r_wr_bank;
    w_nwords_nxt  = r_nwords;
    w_close       = 1'b0;
    w_we          = 1'b0;
    w_err         = 1'b0;
    w_restart     = (r_wst == W_IDLE);
`ifdef ST2BUS_PP_CHECK_EN
    w_restart     = w_restart | ((r_wst == W_FILL) & io.st_sop);
    w_err         = w_beat & (((r_wst == W_IDLE) & ~io.st_sop) | ((r_wst == W_FILL) & io.st_sop));
`endif
    w_take   = w_beat & (((r_wst == W_IDLE) & io.st_sop) | (r_wst == W_FILL));
    w_lane_e = w_restart ? '0 : r_lane;
    w_acc_e  = w_restart ? '0 : r_acc;
    w_wcnt_e = w_restart ? '0 : r_wcnt;
    w_ovf_e  = w_restart ? 1'b0 : r_ovf;
    w_word   = w_acc_e | (BUS_W'(io.st_data) << (int'(w_lane_e) * ST_W));
    w_room   = (w_wcnt_e < c_nw'(MAX_WORDS));
    w_lane_nxt = r_lane;
    w_acc_nxt  = r_acc;
    w_wcnt_nxt = r_wcnt;
    w_ovf_nxt  = r_ovf;

    if (w_take) begin
      w_wst_nxt = W_FILL;
      w_ovf_nxt = w_ovf_e | ~w_room;
      if (!w_room) begin
        // bank already holds MAX_WORDS words: beat is dropped
        w_lane_nxt = w_lane_e;
        w_acc_nxt  = w_acc_e;
        w_wcnt_nxt = w_wcnt_e;
`ifdef ST2BUS_PP_CHECK_EN
        w_err      = 1'b1;
`endif
      end else if ((w_lane_e == c_lw'(c_lanes - 1)) || io.st_eop) begin
        w_we       = 1'b1;
        w_lane_nxt = '0;
        w_acc_nxt  = '0;
        w_wcnt_nxt = w_wcnt_e + 1'b1;
      end else begin
        w_lane_nxt = w_lane_e + 1'b1;
        w_acc_nxt  = w_word;
        w_wcnt_nxt = w_wcnt_e;
      end
      if (io.st_eop) begin
        w_lane_nxt = '0;
        w_acc_nxt  = '0;
        w_wcnt_nxt = '0;
        w_ovf_nxt  = 1'b0;
        w_wst_nxt  = W_IDLE;
`ifdef ST2BUS_PP_CHECK_EN
        w_close    = ~(w_ovf_e | ~w_room);
`else
        w_close    = 1'b1;
`endif
        if (w_close) begin
          w_nwords_nxt[r_wr_bank] = w_room ? (w_wcnt_e + 1'b1) : w_wcnt_e;
          w_wr_bank_nxt           = ~r_wr_bank;
        end
      end
    end

    w_full_nxt = r_full;
    if (w_free)  w_full_nxt[r_rd_bank] = 1'b0;
    if (w_close) w_full_nxt[r_wr_bank] = 1'b1;

    if (w_close && w_full_nxt[~r_wr_bank]) w_wst_nxt = W_WAIT;
    if ((r_wst == W_WAIT) && !w_full_nxt[r_wr_bank]) w_wst_nxt = W_IDLE;
    w_st_ready_nxt = (w_wst_nxt != W_WAIT) & ~w_full_nxt[w_wr_bank_nxt];
  end

  always_ff @(posedge clk_st) begin
    if (!rst_n) begin
      r_wst      <= W_IDLE;
      r_wr_bank  <= 1'b0;
      r_lane     <= '0;
      r_acc      <= '0;
      r_wcnt     <= '0;
      r_ovf      <= 1'b0;
      r_full     <= '0;
      r_nwords   <= '0;
      r_st_ready <= 1'b0;
    end else begin
      r_wst      <= w_wst_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_lane     <= w_lane_nxt;
      r_acc      <= w_acc_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_full     <= w_full_nxt;
      r_nwords   <= w_nwords_nxt;
      r_st_ready <= w_st_ready_nxt;
    end
  end

`ifdef ST2BUS_PP_CHECK_EN
  logic r_err;
  always_ff @(posedge clk_st) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_err;
  end
  assign err_pulse = r_err;
`endif

  st_bank_mem #(.BUS_W(BUS_W), .MAX_WORDS(MAX_WORDS)) u_mem (
    .clk_st  (clk_st),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, w_wcnt_e[c_ww-1:0]}),
    .i_wdata (w_word),
    .i_re    (w_re),
    .i_raddr ({r_rd_bank, r_ridx[c_ww-1:0]}),
    .o_rdata (w_rdata)
  );

  // output + skid + in-flight read may hold at most two words
  assign w_pop       = r_out_valid & io.bus_ready;
  assign w_occ       = 2'(r_out_valid) + 2'(r_sk_valid) + 2'(r_pend);
  assign w_can_issue = (w_occ - 2'(w_pop)) < 2'd2;

  always_comb begin
    w_rst_nxt     = r_rst;
    w_rd_bank_nxt = r_rd_bank;
    w_nw_nxt      = r_nw;
    w_ridx_nxt    = r_ridx;
    w_re          = 1'b0;
    w_free        = 1'b0;
    case (r_rst)
      R_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_nw_nxt   = r_nwords[r_rd_bank];
          w_ridx_nxt = '0;
          w_rst_nxt  = R_FETCH;
        end
      end
      R_FETCH: begin
        w_re       = 1'b1;
        w_ridx_nxt = r_ridx + 1'b1;
        w_rst_nxt  = R_OUT;
      end
      R_OUT: begin
        if ((r_ridx < r_nw) && w_can_issue) begin
          w_re       = 1'b1;
          w_ridx_nxt = r_ridx + 1'b1;
        end
        if (w_pop && r_out_eop) begin
          w_free        = 1'b1;
          w_rd_bank_nxt = ~r_rd_bank;
          w_rst_nxt     = R_IDLE;
        end
      end
      default: w_rst_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_st) begin
    if (!rst_n) begin
      r_rst       <= R_IDLE;
      r_rd_bank   <= 1'b0;
      r_nw        <= '0;
      r_ridx      <= '0;
      r_pend      <= 1'b0;
      r_pend_sop  <= 1'b0;
      r_pend_eop  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_data  <= '0;
      r_sk_valid  <= 1'b0;
      r_sk_sop    <= 1'b0;
      r_sk_eop    <= 1'b0;
      r_sk_data   <= '0;
    end else begin
      r_rst      <= w_rst_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
      r_nw       <= w_nw_nxt;
      r_ridx     <= w_ridx_nxt;
      r_pend     <= w_re;
      r_pend_sop <= (r_ridx == '0);
      r_pend_eop <= (r_ridx == (r_nw - 1'b1));
      if (w_pop || !r_out_valid) begin
        if (r_sk_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_sk_data;
          r_out_sop   <= r_sk_sop;
          r_out_eop   <= r_sk_eop;
          r_sk_valid  <= r_pend;
          if (r_pend) begin
            r_sk_data <= w_rdata;
            r_sk_sop  <= r_pend_sop;
            r_sk_eop  <= r_pend_eop;
          end
        end else if (r_pend) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_rdata;
          r_out_sop   <= r_pend_sop;
          r_out_eop   <= r_pend_eop;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (r_pend) begin
        r_sk_valid <= 1'b1;
        r_sk_data  <= w_rdata;
        r_sk_sop   <= r_pend_sop;
        r_sk_eop   <= r_pend_eop;
      end
    end
  end

  assign io.st_ready   = r_st_ready;
  assign io.bus_valid  = r_out_valid;
  assign io.bus_data   = r_out_data;
  assign io.bus_sop    = r_out_sop;
  assign io.bus_eop    = r_out_eop;
  assign io.bus_nwords = r_nw;

endmodule
`default_nettype wire
